// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Control FSM for the 4-bit processor fetch path. It drives the program
// counter (ENC increment, NBL/LOADC parallel load) and the fetch register
// (ENF), decodes the fetched instruction to sequence single-byte ops,
// two-byte jumps (taken / not-taken) and halt, and provides the ALU execute
// strobe (PHASE).
//
// Ports:
//   CLK     in   system clock, rising edge
//   RESETN  in   asynchronous active-low reset
//   START   in   level; leave IDLE and begin fetching
//   STOP    in   level; return to IDLE at the next instruction boundary
//   INS     in   [3:0] fetched opcode nibble (fetch register high nibble)
//   OPRN    in   [3:0] fetched operand nibble (fetch register low nibble)
//   PRBT    in   [7:0] ROM byte currently addressed by the PC
//   C_FLAG  in   carry flag (sampled in EXEC only)
//   Z_FLAG  in   zero flag (sampled in EXEC only)
//   ENC     out  PC increment enable
//   ENF     out  fetch register capture enable
//   NBL     out  PC parallel load
//   LOADC   out  [11:0] PC load value, {OPRN,PRBT} during JMPLD else 0
//   PHASE   out  ALU execute strobe, 1 in EXEC
//   HALTED  out  1 in HALT
//   ICOUNT  out  [7:0] executed instruction count, wraps 255->0
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [3:0] JMP_OP = 4'b1111,
  parameter logic [3:0] JC_OP  = 4'b1110,
  parameter logic [3:0] JZ_OP  = 4'b1101,
  parameter logic [3:0] HLT_OP = 4'b0000
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        START,
  input  logic        STOP,
  input  logic [3:0]  INS,
  input  logic [3:0]  OPRN,
  input  logic [7:0]  PRBT,
  input  logic        C_FLAG,
  input  logic        Z_FLAG,
  output logic        ENC,
  output logic        ENF,
  output logic        NBL,
  output logic [11:0] LOADC,
  output logic        PHASE,
  output logic        HALTED,
  output logic [7:0]  ICOUNT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_JMPLD = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  icount_q, icount_d;
  logic        enf_q, enf_d;
  logic        nbl_q, nbl_d;
  logic        phase_q, phase_d;
  logic        halted_q, halted_d;
  logic        enc_c;

  // Opcode decode; only consulted while in EXEC so an unknown INS in any
  // other state cannot disturb the sequencing.
  logic is_hlt, jmp_taken, jmp_not_taken;

  always_comb begin
    is_hlt        = (INS == HLT_OP);
    jmp_taken     = (INS == JMP_OP) ||
                    ((INS == JC_OP) && C_FLAG) ||
                    ((INS == JZ_OP) && Z_FLAG);
    jmp_not_taken = ((INS == JC_OP) && !C_FLAG) ||
                    ((INS == JZ_OP) && !Z_FLAG);
  end

  always_comb begin
    state_d  = state_q;
    icount_d = icount_q;
    enc_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // STOP wins a START/STOP race.
        if (START && !STOP) state_d = S_FETCH;
      end
      S_FETCH: begin
        // PC steps past the opcode byte on the same edge the fetch
        // register captures it.
        enc_c   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        icount_d = icount_q + 8'd1;
        if (is_hlt) begin
          state_d = S_HALT;
        end else if (jmp_taken) begin
          // PC stays on the target-low byte so JMPLD can read it on PRBT.
          state_d = S_JMPLD;
        end else begin
          // A not-taken conditional jump skips its second byte here.
          enc_c   = jmp_not_taken;
          state_d = STOP ? S_IDLE : S_FETCH;
        end
      end
      S_JMPLD: begin
        state_d = STOP ? S_IDLE : S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Moore strobes are precomputed from the next state so they leave
    // the flops glitch-free and clear instantly on reset.
    enf_d    = (state_d == S_FETCH);
    phase_d  = (state_d == S_EXEC);
    nbl_d    = (state_d == S_JMPLD);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= S_IDLE;
      icount_q <= 8'd0;
      enf_q    <= 1'b0;
      nbl_q    <= 1'b0;
      phase_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
      enf_q    <= enf_d;
      nbl_q    <= nbl_d;
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  assign ENC    = enc_c;
  assign ENF    = enf_q;
  assign NBL    = nbl_q;
  assign PHASE  = phase_q;
  assign HALTED = halted_q;
  assign ICOUNT = icount_q;
  // The jump target is assembled from the live second ROM byte, so it is
  // combinational and gated by the registered load strobe.
  assign LOADC  = nbl_q ? {OPRN, PRBT} : 12'h000;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. The stimulus process drives inputs just
// after each rising edge and pushes the hand-computed expected outputs for
// that cycle into a queue; the monitor pops one entry on each falling edge
// and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        START;
  logic        STOP;
  logic [3:0]  INS;
  logic [3:0]  OPRN;
  logic [7:0]  PRBT;
  logic        C_FLAG;
  logic        Z_FLAG;
  logic        ENC;
  logic        ENF;
  logic        NBL;
  logic [11:0] LOADC;
  logic        PHASE;
  logic        HALTED;
  logic [7:0]  ICOUNT;

  fetch_sequencer dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .START  (START),
    .STOP   (STOP),
    .INS    (INS),
    .OPRN   (OPRN),
    .PRBT   (PRBT),
    .C_FLAG (C_FLAG),
    .Z_FLAG (Z_FLAG),
    .ENC    (ENC),
    .ENF    (ENF),
    .NBL    (NBL),
    .LOADC  (LOADC),
    .PHASE  (PHASE),
    .HALTED (HALTED),
    .ICOUNT (ICOUNT)
  );

  always #5 CLK = ~CLK;

  // Strobe vectors {ENC, ENF, NBL, PHASE, HALTED}
  localparam logic [4:0] X_IDL = 5'b00000;
  localparam logic [4:0] X_FET = 5'b11000;
  localparam logic [4:0] X_EXE = 5'b00010;
  localparam logic [4:0] X_EXN = 5'b10010;  // EXEC of a not-taken jump
  localparam logic [4:0] X_JLD = 5'b00100;
  localparam logic [4:0] X_HLT = 5'b00001;

  typedef struct {
    string       name;
    logic [24:0] v;   // {strobes[4:0], loadc[11:0], icount[7:0]}
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [24:0] act;
  int          tests = 0;
  int          fails = 0;

  // Monitor: one transaction per falling edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      act   = {ENC, ENF, NBL, PHASE, HALTED, LOADC, ICOUNT};
      tests++;
      if (act !== mon_e.v) begin
        fails++;
        $display("FAIL %s: got strobes=%b loadc=%h icount=%0d, expected strobes=%b loadc=%h icount=%0d",
                 mon_e.name, act[24:20], act[19:8], act[7:0],
                 mon_e.v[24:20], mon_e.v[19:8], mon_e.v[7:0]);
      end else begin
        $display("[TB] %s strobes=%b loadc=%h icount=%0d",
                 mon_e.name, act[24:20], act[19:8], act[7:0]);
      end
      tests++;
      if (ENC && NBL) begin
        fails++;
        $display("FAIL %s_enc_nbl_exclusive: got ENC=%b NBL=%b, expected not both 1",
                 mon_e.name, ENC, NBL);
      end
    end
  end

  task automatic cyc(input string name, input logic [4:0] s,
                     input logic [11:0] lc, input logic [7:0] ic);
    exp_t e;
    e.name = name;
    e.v    = {s, lc, ic};
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESETN = 1'b0; START = 1'b0; STOP = 1'b0;
    INS = 4'h0; OPRN = 4'h0; PRBT = 8'h00; C_FLAG = 1'b0; Z_FLAG = 1'b0;
    @(posedge CLK);
    #1;

    // Reset and idle
    cyc("reset_hold", X_IDL, 12'h000, 8'd0);
    cyc("reset_hold", X_IDL, 12'h000, 8'd0);
    RESETN = 1'b1;
    for (int i = 0; i < 5; i++) cyc("idle", X_IDL, 12'h000, 8'd0);

    // Single-byte run
    START = 1'b1; INS = 4'h3;
    cyc("start_seen", X_IDL, 12'h000, 8'd0);
    for (int i = 0; i < 3; i++) begin
      cyc("single_fetch", X_FET, 12'h000, 8'(i));
      cyc("single_exec",  X_EXE, 12'h000, 8'(i));
    end

    // Unconditional jump
    INS = 4'hF; OPRN = 4'h2; PRBT = 8'h34;
    cyc("jmp_fetch", X_FET, 12'h000, 8'd3);
    cyc("jmp_exec",  X_EXE, 12'h000, 8'd3);
    cyc("jmp_load",  X_JLD, 12'h234, 8'd4);

    // JC not taken / taken
    INS = 4'hE; C_FLAG = 1'b0;
    cyc("jc_fetch",   X_FET, 12'h000, 8'd4);
    cyc("jc_nt_exec", X_EXN, 12'h000, 8'd4);
    C_FLAG = 1'b1; OPRN = 4'hA; PRBT = 8'hBC;
    cyc("jc_fetch",   X_FET, 12'h000, 8'd5);
    cyc("jc_t_exec",  X_EXE, 12'h000, 8'd5);
    cyc("jc_t_load",  X_JLD, 12'hABC, 8'd6);

    // JZ not taken / taken (carry set to show it is ignored for JZ)
    INS = 4'hD; C_FLAG = 1'b1; Z_FLAG = 1'b0;
    cyc("jz_fetch",   X_FET, 12'h000, 8'd6);
    cyc("jz_nt_exec", X_EXN, 12'h000, 8'd6);
    C_FLAG = 1'b0; Z_FLAG = 1'b1; OPRN = 4'h5; PRBT = 8'h67;
    cyc("jz_fetch",   X_FET, 12'h000, 8'd7);
    cyc("jz_t_exec",  X_EXE, 12'h000, 8'd7);
    cyc("jz_t_load",  X_JLD, 12'h567, 8'd8);

    // JC with only Z set is not taken
    INS = 4'hE; C_FLAG = 1'b0; Z_FLAG = 1'b1;
    cyc("jc_fetch",     X_FET, 12'h000, 8'd8);
    cyc("jc_zonly_exec", X_EXN, 12'h000, 8'd8);

    // STOP during FETCH: instruction completes, then IDLE; START=STOP=1 stays
    INS = 4'h3; Z_FLAG = 1'b0; STOP = 1'b1;
    cyc("stop_fetch", X_FET, 12'h000, 8'd9);
    cyc("stop_exec",  X_EXE, 12'h000, 8'd9);
    for (int i = 0; i < 4; i++) cyc("race_idle", X_IDL, 12'h000, 8'd10);
    STOP = 1'b0;
    cyc("resume_idle",  X_IDL, 12'h000, 8'd10);
    cyc("resume_fetch", X_FET, 12'h000, 8'd10);

    // STOP during JMPLD returns to IDLE after the load
    INS = 4'hF; OPRN = 4'h1; PRBT = 8'h23;
    cyc("jmp2_exec", X_EXE, 12'h000, 8'd10);
    STOP = 1'b1;
    cyc("stop_jmpld",     X_JLD, 12'h123, 8'd11);
    cyc("stop_after_jmp", X_IDL, 12'h000, 8'd11);
    STOP = 1'b0;
    cyc("restart_idle", X_IDL, 12'h000, 8'd11);

    // Halt: sticky with START held
    INS = 4'h0;
    cyc("hlt_fetch", X_FET, 12'h000, 8'd11);
    cyc("hlt_exec",  X_EXE, 12'h000, 8'd11);
    INS = 4'hF; C_FLAG = 1'b1;
    for (int i = 0; i < 10; i++) cyc("halted", X_HLT, 12'h000, 8'd12);

    // Reset asserted between clock edges clears outputs immediately
    RESETN = 1'b0;
    cyc("async_rst", X_IDL, 12'h000, 8'd0);
    cyc("rst_hold",  X_IDL, 12'h000, 8'd0);
    RESETN = 1'b1; INS = 4'h3; C_FLAG = 1'b0;
    cyc("post_rst_idle", X_IDL, 12'h000, 8'd0);

    // 257 instructions: ICOUNT wraps 255 -> 0
    for (int i = 0; i <= 256; i++) begin
      cyc("wrap_fetch", X_FET, 12'h000, 8'(i));
      cyc("wrap_exec",  X_EXE, 12'h000, 8'(i));
    end

    // Reset in JMPLD abandons the jump without NBL
    INS = 4'hF; OPRN = 4'h9; PRBT = 8'hAB;
    cyc("jrst_fetch", X_FET, 12'h000, 8'd1);
    cyc("jrst_exec",  X_EXE, 12'h000, 8'd1);
    RESETN = 1'b0;
    cyc("jmpld_rst", X_IDL, 12'h000, 8'd0);
    RESETN = 1'b1; START = 1'b0;
    cyc("rst_idle", X_IDL, 12'h000, 8'd0);
    cyc("rst_idle", X_IDL, 12'h000, 8'd0);

    // Every pushed expectation must have been consumed
    @(posedge CLK);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
